multiplier_iterative_param: RTL

Parametrised multi-cycle integer multiplier; next generation of the team's nibble-serial iterative multiplier.
- Generalised in operand width and digit (radix) size.
- Adds signed/unsigned mode, full valid/ready handshakes on both sides and a held result.
- Targets the CPU's MULT/MULTU path, where area matters more than latency.

---
 rtl/multiplier_iterative_param.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/multiplier_iterative_param.sv
// multiplier_iterative_param
//
// Multi-cycle integer multiplier that consumes DIGIT multiplier bits per
// clock.
//   - Signed operands are reduced to magnitudes on accept.
//   - The sign is reapplied in a single FIX cycle.
//   - The product is held in DONE until the consumer takes it.
//
// Optional build macro: MULT_ITER_EARLY_TERM_EN
//   Defined   -> RUN exits as soon as the remaining multiplier magnitude is
//                zero (data-dependent latency, minimum one iteration).
//   Undefined -> RUN always performs exactly WIDTH/DIGIT iterations.
//   Product values are identical in both builds.
//
// WIDTH must be a multiple of DIGIT.
//
// Handshake semantics (both sides are strict valid/ready):
//   - Input transfer happens on a rising edge where in_valid && in_ready.
//     in_ready is high only in IDLE. in_valid seen in any other state is
//     ignored and the operands are not sampled.
//   - Output transfer happens on a rising edge where out_valid && out_ready.
//     out_valid is high only in DONE, and r is stable for as long as
//     out_valid is high. out_ready seen outside DONE is ignored.
//   - After an output transfer the block is in IDLE on the next cycle. A new
//     input therefore cannot be taken on the same edge that retires a
//     result.
//
// state_dbg exposes the FSM state: 0=IDLE, 1=RUN, 2=FIX, 3=DONE.

module multiplier_iterative_param #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   r,
    output logic                 busy,
    output logic [1:0]           state_dbg
);

    // Number of iterations needed to consume the whole multiplier.
    localparam int N     = WIDTH / DIGIT;
    // Sized so that the value N-1 always fits, even when N is 1.
    localparam int CNT_W = (N > 1) ? $clog2(N + 1) : 1;
    localparam int PW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    // Datapath registers.
    logic [WIDTH-1:0] mp_q;   // remaining multiplier magnitude
    logic [PW-1:0]    mc_q;   // multiplicand magnitude, pre-shifted per digit
    logic [PW-1:0]    acc_q;  // running unsigned product magnitude
    logic [CNT_W-1:0] cnt_q;  // iterations completed so far
    logic             neg_q;  // final product must be negated

    // Combinational helpers.
    logic             accept;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             neg_in;
    logic [PW-1:0]    digit_ext;
    logic [PW-1:0]    partial;
    logic [PW-1:0]    acc_nxt;
    logic [WIDTH-1:0] mp_shift;
    logic [PW-1:0]    mc_shift;
    logic             last_iter;
    logic [PW-1:0]    signed_result;

    // ------------------------------------------------------------------
    // Operand conditioning on accept.
    //
    // The signedness mode is fully absorbed here. It is folded into the
    // two magnitudes and the neg flag, so it never needs its own register.
    // The most negative operand negates to 2^(WIDTH-1). That value still
    // fits in WIDTH bits when the result is read as unsigned.
    // ------------------------------------------------------------------

    // Magnitudes and result sign of the incoming operands.
    always_comb begin
        accept = in_valid && (state_q == S_IDLE);
        mag_a  = (is_signed && a[WIDTH-1]) ? ({WIDTH{1'b0}} - a) : a;
        mag_b  = (is_signed && b[WIDTH-1]) ? ({WIDTH{1'b0}} - b) : b;
        // A zero operand forces a positive result, so -0 is never formed.
        neg_in = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]) && (|a) && (|b);
    end

    // ------------------------------------------------------------------
    // One radix-2^DIGIT iteration.
    // ------------------------------------------------------------------

    // Partial product of the low multiplier digit, plus the shifted operands.
    always_comb begin
        digit_ext = {{(PW - DIGIT){1'b0}}, mp_q[DIGIT-1:0]};
        partial   = digit_ext * mc_q;
        acc_nxt   = acc_q + partial;
        mp_shift  = mp_q >> DIGIT;
        mc_shift  = mc_q << DIGIT;
`ifdef MULT_ITER_EARLY_TERM_EN
        // Stop after the Nth digit, or as soon as no nonzero digit remains.
        last_iter = (cnt_q == CNT_W'(N - 1)) || (mp_shift == {WIDTH{1'b0}});
`else
        // Always stop after exactly N digits, for a fixed latency.
        last_iter = (cnt_q == CNT_W'(N - 1));
`endif
        signed_result = neg_q ? ({PW{1'b0}} - acc_q) : acc_q;
    end

    // ------------------------------------------------------------------
    // FSM: state register, next-state logic, output decode.
    // ------------------------------------------------------------------

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid)  state_d = S_RUN;
            S_RUN:  if (last_iter) state_d = S_FIX;
            S_FIX:                 state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    // Handshake and status outputs, all decoded directly from the state.
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q == S_RUN) || (state_q == S_FIX);
        state_dbg = state_q;
    end

    // ------------------------------------------------------------------
    // Datapath registers.
    // ------------------------------------------------------------------

    // Operand load on accept, digit iteration in RUN, and sign fix-up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mp_q  <= {WIDTH{1'b0}};
            mc_q  <= {PW{1'b0}};
            acc_q <= {PW{1'b0}};
            cnt_q <= {CNT_W{1'b0}};
            neg_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        mp_q  <= mag_a;
                        mc_q  <= {{WIDTH{1'b0}}, mag_b};
                        acc_q <= {PW{1'b0}};
                        cnt_q <= {CNT_W{1'b0}};
                        neg_q <= neg_in;
                    end
                end
                S_RUN: begin
                    acc_q <= acc_nxt;
                    mp_q  <= mp_shift;
                    mc_q  <= mc_shift;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                default: begin
                    // FIX and DONE leave the iteration state untouched.
                end
            endcase
        end
    end

    // Result register.
    // Written only in FIX; holds its value through DONE and the idle time
    // that follows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r <= {PW{1'b0}};
        end else if (state_q == S_FIX) begin
            r <= signed_result;
        end
    end

endmodule
